// File: rtl/shift_line_pkg.sv
// Shared definitions for the multi-mode shift line: mode encoding and small helpers.
package shift_line_pkg;

    typedef enum logic [1:0] {
        SHIFT_FWD = 2'b00,
        SHIFT_REV = 2'b01,
        ROTATE    = 2'b10,
        FLUSH     = 2'b11
    } mode_e;

    localparam int MODE_W = 2;

    // Modes that move an entry in from din and one out to dout.
    function automatic logic is_shift(input mode_e m);
        return (m == SHIFT_FWD) || (m == SHIFT_REV);
    endfunction

endpackage

// File: rtl/shift_line_stage.sv
// One stage of the shift line: picks its next contents from the neighbour chosen by mode.
module shift_line_stage
    import shift_line_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] fwd_data,
    input  logic             fwd_vld,
    input  logic [WIDTH-1:0] rev_data,
    input  logic             rev_vld,
    input  logic [WIDTH-1:0] rot_data,
    input  logic             rot_vld,
    output logic [WIDTH-1:0] q_data,
    output logic             q_vld
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_data <= '0;
            q_vld  <= 1'b0;
        end else if (en) begin
            case (mode)
                SHIFT_FWD: begin
                    q_data <= fwd_data;
                    q_vld  <= fwd_vld;
                end
                SHIFT_REV: begin
                    q_data <= rev_data;
                    q_vld  <= rev_vld;
                end
                ROTATE: begin
                    q_data <= rot_data;
                    q_vld  <= rot_vld;
                end
                default: begin
                    q_data <= '0;
                    q_vld  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_line.sv
// Parametrised shift line: forward/reverse shift, rotate and flush over DEPTH stages,
// with a registered exit port, a combinational tap and an incrementally kept occupancy.
module shift_line
    import shift_line_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int TAPW  = $clog2(DEPTH),
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic [TAPW-1:0]  tap_sel,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [WIDTH-1:0] tap_out,
    output logic             tap_valid,
    output logic [CNTW-1:0]  count
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             vld;
    } stage_t;

    mode_e                       m;
    logic [DEPTH-1:0][WIDTH-1:0] st_data;
    logic [DEPTH-1:0]            st_vld;
    stage_t                      exit_st;
    logic                        enter_v;

    assign m = mode_e'(mode);

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        localparam int PREV = (i == 0) ? DEPTH - 1 : i - 1;
        localparam int NEXT = (i == DEPTH - 1) ? 0 : i + 1;

        // Ends of the line take din; rotate closes the ring from the last stage into stage 0.
        logic [WIDTH-1:0] fwd_d, rev_d;
        logic             fwd_v, rev_v;

        assign fwd_d = (i == 0)         ? din       : st_data[PREV];
        assign fwd_v = (i == 0)         ? din_valid : st_vld[PREV];
        assign rev_d = (i == DEPTH - 1) ? din       : st_data[NEXT];
        assign rev_v = (i == DEPTH - 1) ? din_valid : st_vld[NEXT];

        shift_line_stage #(.WIDTH(WIDTH)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .mode     (m),
            .fwd_data (fwd_d),
            .fwd_vld  (fwd_v),
            .rev_data (rev_d),
            .rev_vld  (rev_v),
            .rot_data (st_data[PREV]),
            .rot_vld  (st_vld[PREV]),
            .q_data   (st_data[i]),
            .q_vld    (st_vld[i])
        );
    end

    always_comb begin
        exit_st = '0;
        enter_v = din_valid;
        if (m == SHIFT_REV) begin
            exit_st.data = st_data[0];
            exit_st.vld  = st_vld[0];
        end else begin
            exit_st.data = st_data[DEPTH-1];
            exit_st.vld  = st_vld[DEPTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            count      <= '0;
        end else if (en) begin
            case (m)
                SHIFT_FWD, SHIFT_REV: begin
                    dout       <= exit_st.data;
                    dout_valid <= exit_st.vld;
                end
                ROTATE: begin
                    dout       <= exit_st.data;
                    dout_valid <= 1'b0;
                end
                default: begin
                    dout       <= '0;
                    dout_valid <= 1'b0;
                end
            endcase

            if (m == FLUSH)
                count <= '0;
            else if (is_shift(m) && enter_v && !exit_st.vld)
                count <= count + CNTW'(1);
            else if (is_shift(m) && !enter_v && exit_st.vld)
                count <= count - CNTW'(1);
        end
    end

    // Unmatched tap_sel (only possible for non-power-of-2 DEPTH) reads as empty.
    always_comb begin
        tap_out   = '0;
        tap_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TAPW'(i)) begin
                tap_out   = st_data[i];
                tap_valid = st_vld[i];
            end
        end
    end

endmodule

// File: tb/tb_shift_line.sv
// Randomized + directed scoreboard bench for shift_line, using a queue-based line model.
module tb_shift_line;

    localparam int W    = 4;
    localparam int D    = 5;
    localparam int TAPW = $clog2(D);
    localparam int CNTW = $clog2(D + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en = 1'b0;
    logic [1:0]      mode = 2'b00;
    logic [W-1:0]    din = '0;
    logic            din_valid = 1'b0;
    logic [TAPW-1:0] tap_sel = '0;
    logic [W-1:0]    dout;
    logic            dout_valid;
    logic [W-1:0]    tap_out;
    logic            tap_valid;
    logic [CNTW-1:0] count;

    shift_line #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din), .din_valid(din_valid),
        .tap_sel(tap_sel), .dout(dout), .dout_valid(dout_valid), .tap_out(tap_out),
        .tap_valid(tap_valid), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         v;
    } ent_t;

    typedef struct {
        int dout;
        int dv;
        int cnt;
        int tap;
        int tapv;
    } exp_t;

    ent_t line[$];
    exp_t expq[$];
    int   m_dout = 0;
    int   m_dv   = 0;
    int   tests  = 0;
    int   fails  = 0;

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic clear_line();
        ent_t z;
        z.d = '0;
        z.v = 1'b0;
        line.delete();
        for (int i = 0; i < D; i++) line.push_back(z);
        m_dout = 0;
        m_dv   = 0;
    endtask

    // Drive one cycle of inputs and record what the line should show after the edge.
    task automatic step(input logic r, input logic e, input logic [1:0] md,
                        input logic [W-1:0] d, input logic dv);
        ent_t nw, ex;
        exp_t x;
        int   ts;
        @(negedge clk);
        ts        = $urandom_range(0, (1 << TAPW) - 1);
        rst       = r;
        en        = e;
        mode      = md;
        din       = d;
        din_valid = dv;
        tap_sel   = TAPW'(ts);
        nw.d = d;
        nw.v = dv;
        if (r) clear_line();
        else if (e) begin
            case (md)
                2'b00: begin
                    ex = line.pop_back();
                    line.push_front(nw);
                    m_dout = int'(ex.d);
                    m_dv   = int'(ex.v);
                end
                2'b01: begin
                    ex = line.pop_front();
                    line.push_back(nw);
                    m_dout = int'(ex.d);
                    m_dv   = int'(ex.v);
                end
                2'b10: begin
                    ex = line.pop_back();
                    line.push_front(ex);
                    m_dout = int'(ex.d);
                    m_dv   = 0;
                end
                default: clear_line();
            endcase
        end
        x.dout = m_dout;
        x.dv   = m_dv;
        x.cnt  = 0;
        foreach (line[i]) x.cnt += int'(line[i].v);
        x.tap  = (ts < D) ? int'(line[ts].d) : 0;
        x.tapv = (ts < D) ? int'(line[ts].v) : 0;
        expq.push_back(x);
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (expq.size() > 0) begin
            x = expq.pop_front();
            chk("dout", int'(dout), x.dout);
            chk("dout_valid", int'(dout_valid), x.dv);
            chk("count", int'(count), x.cnt);
            chk("tap_out", int'(tap_out), x.tap);
            chk("tap_valid", int'(tap_valid), x.tapv);
        end
    end

    initial begin
        logic [1:0] md;
        int         r;
        clear_line();

        step(1, 0, 2'b00, 4'h0, 0);
        // forward latency: 1..5 then bubbles
        for (int i = 1; i <= 5; i++) step(0, 1, 2'b00, W'(i), 1);
        for (int i = 0; i < 7; i++) step(0, 1, 2'b00, 4'h0, 0);
        // same stream with en gaps
        step(1, 1, 2'b00, 4'h0, 0);
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 2'b00, W'(i), 1);
            step(0, 0, 2'b00, 4'hE, 1);
        end
        for (int i = 0; i < 12; i++) step(0, i % 2, 2'b00, 4'h0, 0);
        // reset mid-stream
        for (int i = 0; i < 3; i++) step(0, 1, 2'b00, W'(i + 8), 1);
        step(1, 1, 2'b00, 4'h3, 1);
        step(0, 0, 2'b00, 4'h0, 0);
        // reverse load, then full rotation
        for (int i = 0; i < D; i++) step(0, 1, 2'b01, W'(10 + i), 1);
        for (int i = 0; i < D; i++) step(0, 1, 2'b10, 4'h1, 1);
        // full line keeps count, oldest exits
        step(0, 1, 2'b01, 4'h2, 1);
        // mixed valids
        step(0, 1, 2'b11, 4'h0, 0);
        step(0, 1, 2'b00, 4'h7, 1);
        step(0, 1, 2'b00, 4'hF, 0);
        step(0, 1, 2'b00, 4'h9, 1);
        for (int i = 0; i < D + 1; i++) step(0, 1, 2'b00, 4'h0, 0);
        // flush gated by en, then effective
        for (int i = 0; i < D; i++) step(0, 1, 2'b00, W'(i + 3), 1);
        step(0, 0, 2'b11, 4'h0, 0);
        step(0, 1, 2'b11, 4'h0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 2'b10, 4'h0, 0);

        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 15);
            md = (r < 7) ? 2'b00 : (r < 12) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0), md,
                 W'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
